// File: rtl/dram_pkg.sv
// Shared types and helpers for the DRAM read sequencer.
package dram_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, LAT, XFER, GAP, DONE} rd_state_t;

    typedef logic [1:0] burst_size_t;

    localparam int unsigned BURST_MAX = 8;

    // Capture-window length in clk cycles for a given burst size code.
    function automatic logic [2:0] beat_cycles(input burst_size_t size);
        case (size)
            2'd0, 2'd1: beat_cycles = 3'd1;
            2'd2:       beat_cycles = 3'd2;
            default:    beat_cycles = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dram_rd_timer.sv
// Loadable down-counter; zero flags that the count reaches zero at the coming edge,
// so a load of N keeps a state for exactly N cycles.
module dram_rd_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count <= {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dram_read_sequencer.sv
// Issues one READ per burst, waits CAS latency, opens the buffer capture window, pulses rd_done.
// Optional DQS watchdog enabled by defining DRAM_RD_TIMEOUT_EN.
module dram_read_sequencer
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned CAS_LAT = 5,
    parameter int unsigned GAP_CYC = 1,
    parameter int unsigned TMO_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [2:0]        req_count,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              cmd_read,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [1:0]        buf_burst_size,
    output logic              buf_capture_en,
    input  logic              dqs_seen,
    output logic              rd_done,
    output logic              busy,
    output logic              err_timeout
);

    rd_state_t         state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        remaining;
    logic              accept, burst_end, more, xfer_ok, wd_fire;
    logic              tmr_load, tmr_zero;
    logic [3:0]        tmr_val;

    assign accept    = (state == IDLE) && req_valid;
    assign more      = (remaining != 4'd1);
    assign burst_end = (state == XFER) && tmr_zero && xfer_ok;

    dram_rd_timer #(.W(4)) u_seq_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // buf_burst_size doubles as the latched request size.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            remaining      <= '0;
            buf_burst_size <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr           <= req_addr;
                remaining      <= (req_count == 3'd0) ? 4'(BURST_MAX) : {1'b0, req_count};
                buf_burst_size <= req_size;
            end else if (burst_end) begin
                remaining <= remaining - 1'b1;
                if (more) begin
                    addr <= addr + (ADDR_W'(1) << buf_burst_size);
                end
            end
        end
    end

    always_comb begin
        state_n        = state;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        req_ready      = 1'b0;
        cmd_read       = 1'b0;
        cmd_addr       = '0;
        buf_capture_en = 1'b0;
        rd_done        = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_n = ISSUE;
            end
            ISSUE: begin
                cmd_read = 1'b1;
                cmd_addr = addr;
                tmr_load = 1'b1;
                tmr_val  = 4'(CAS_LAT - 1);
                state_n  = LAT;
            end
            LAT: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = {1'b0, beat_cycles(buf_burst_size)};
                    state_n  = XFER;
                end
            end
            XFER: begin
                buf_capture_en = 1'b1;
                if (burst_end) begin
                    if (!more) begin
                        state_n = DONE;
                    end else if (GAP_CYC == 0) begin
                        state_n = ISSUE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = 4'(GAP_CYC);
                        state_n  = GAP;
                    end
                end
            end
            GAP: begin
                if (tmr_zero) state_n = ISSUE;
            end
            DONE: begin
                rd_done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (wd_fire) state_n = DONE;
    end

`ifdef DRAM_RD_TIMEOUT_EN
    localparam int unsigned WD_W = 5;

    logic wd_armed, wd_zero;

    dram_rd_timer #(.W(WD_W)) u_wd_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ISSUE),
        .load_val (WD_W'(CAS_LAT + TMO_CYC - 1)),
        .zero     (wd_zero)
    );

    // While armed the capture window stays open past its beat count until a strobe arrives.
    assign wd_fire = wd_armed && wd_zero && !dqs_seen;
    assign xfer_ok = !wd_armed || dqs_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_armed    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd_armed <= 1'b1;
            end else if (dqs_seen || wd_fire) begin
                wd_armed <= 1'b0;
            end
            if (wd_fire) err_timeout <= 1'b1;
        end
    end
`else
    logic dqs_unused;

    assign dqs_unused  = dqs_seen;
    assign wd_fire     = 1'b0;
    assign xfer_ok     = 1'b1;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dram_read_sequencer.sv
// Self-checking bench: closed-form timing model of the request schedule plus directed literal pins.
module tb_dram_read_sequencer;

    localparam int ADDR_W  = 16;
    localparam int CAS_LAT = 5;
    localparam int GAP_CYC = 1;
    localparam int TMO_CYC = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_size = '0;
    logic [2:0]        req_count = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              cmd_read;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        buf_burst_size;
    logic              buf_capture_en;
    logic              dqs_seen = 1'b0;
    logic              rd_done;
    logic              busy;
    logic              err_timeout;

    dram_read_sequencer #(
        .ADDR_W  (ADDR_W),
        .CAS_LAT (CAS_LAT),
        .GAP_CYC (GAP_CYC),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_size       (req_size),
        .req_count      (req_count),
        .req_addr       (req_addr),
        .cmd_read       (cmd_read),
        .cmd_addr       (cmd_addr),
        .buf_burst_size (buf_burst_size),
        .buf_capture_en (buf_capture_en),
        .dqs_seen       (dqs_seen),
        .rd_done        (rd_done),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit started = 0;

    // Model state: the one request in flight, described by its accept cycle and parameters.
    bit          m_active = 0;
    int          m_a = 0;
    int          m_n = 1;
    int          m_size = 0;
    logic [15:0] m_base = '0;
    logic [1:0]  m_buf = '0;

    int          cmd_cyc[$];
    logic [15:0] cmd_adr[$];
    int          cap_cyc[$];
    int          done_cyc[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int beats(input int s);
        return (s == 3) ? 4 : (s == 2) ? 2 : 1;
    endfunction

    function automatic int period(input int s);
        return CAS_LAT + beats(s) + GAP_CYC;
    endfunction

    function automatic int done_off();
        return m_n * period(m_size) - GAP_CYC;
    endfunction

    function automatic bit m_busy(input int c);
        return m_active && (c > m_a) && (c <= m_a + 1 + done_off());
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 0;
            m_buf    <= '0;
        end else if (!m_busy(cyc) && req_valid) begin
            m_active <= 1;
            m_a      <= cyc;
            m_n      <= (req_count == 3'd0) ? 8 : int'(req_count);
            m_size   <= int'(req_size);
            m_base   <= req_addr;
            m_buf    <= req_size;
        end
        cyc     <= cyc + 1;
        started <= 1;
    end

    always @(negedge clk) begin
        if (started) begin
            logic        e_busy, e_cmd, e_cap, e_done;
            logic [15:0] e_addr;
            int          off, p, b, r;
            e_busy = m_busy(cyc);
            e_cmd  = 0;
            e_cap  = 0;
            e_done = 0;
            e_addr = '0;
            if (e_busy) begin
                off = cyc - m_a - 1;
                p   = period(m_size);
                b   = off / p;
                r   = off % p;
                if (off == done_off()) begin
                    e_done = 1;
                end else begin
                    e_cmd = (r == 0);
                    e_cap = (r >= CAS_LAT) && (r < CAS_LAT + beats(m_size));
                    if (e_cmd) e_addr = m_base + 16'(b << m_size);
                end
            end
            chk("req_ready", req_ready, !e_busy);
            chk("busy", busy, e_busy);
            chk("cmd_read", cmd_read, e_cmd);
            chk("cmd_addr", cmd_addr, e_addr);
            chk("capture_en", buf_capture_en, e_cap);
            chk("rd_done", rd_done, e_done);
            chk("burst_size", buf_burst_size, m_buf);
            chk("err_timeout", err_timeout, 1'b0);
            if (cmd_read === 1'b1) begin
                cmd_cyc.push_back(cyc);
                cmd_adr.push_back(cmd_addr);
            end
            if (buf_capture_en === 1'b1) cap_cyc.push_back(cyc);
            if (rd_done === 1'b1) done_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        cmd_cyc.delete();
        cmd_adr.delete();
        cap_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) chk("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic send(input logic [1:0] s, input logic [2:0] n, input logic [15:0] a);
        req_valid = 1'b1;
        req_size  = s;
        req_count = n;
        req_addr  = a;
        wait_ready();
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cmd", cmd_read, 1'b0);
        rst = 1'b0;
        tick();

        // Single burst: capture exactly CAS_LAT after the READ, done one cycle later.
        clear_logs();
        send(2'd1, 3'd1, 16'h0100);
        wait_ready();
        chk("single_cmds", cmd_cyc.size(), 1);
        chk("single_caps", cap_cyc.size(), 1);
        chk("single_dones", done_cyc.size(), 1);
        if (cmd_cyc.size() == 1 && cap_cyc.size() == 1 && done_cyc.size() == 1) begin
            chk("single_addr", cmd_adr[0], 16'h0100);
            chk("single_lat", cap_cyc[0] - cmd_cyc[0], 5);
            chk("single_done", done_cyc[0] - cap_cyc[0], 1);
        end

        // Eight 8-byte bursts.
        clear_logs();
        send(2'd3, 3'd0, 16'h0000);
        wait_ready();
        chk("burst_cmds", cmd_cyc.size(), 8);
        chk("burst_caps", cap_cyc.size(), 32);
        chk("burst_dones", done_cyc.size(), 1);
        if (cmd_cyc.size() == 8 && cap_cyc.size() == 32) begin
            for (int i = 0; i < 8; i++) chk("burst_addr", cmd_adr[i], 32'(i * 8));
            chk("burst_span", cap_cyc[31] - cmd_cyc[0] + 1, 79);
        end

        // Address wrap at the top of the space.
        clear_logs();
        send(2'd2, 3'd2, 16'hFFFC);
        wait_ready();
        chk("wrap_cmds", cmd_cyc.size(), 2);
        if (cmd_cyc.size() == 2) begin
            chk("wrap_addr0", cmd_adr[0], 16'hFFFC);
            chk("wrap_addr1", cmd_adr[1], 16'h0000);
        end

        // Request held valid with new values while busy.
        clear_logs();
        req_valid = 1'b1;
        req_size  = 2'd0;
        req_count = 3'd1;
        req_addr  = 16'h0200;
        wait_ready();
        tick();
        req_count = 3'd2;
        req_addr  = 16'h0300;
        wait_ready();
        tick();
        req_valid = 1'b0;
        wait_ready();
        chk("bp_cmds", cmd_cyc.size(), 3);
        if (cmd_cyc.size() == 3 && done_cyc.size() == 2) begin
            chk("bp_addr0", cmd_adr[0], 16'h0200);
            chk("bp_addr1", cmd_adr[1], 16'h0300);
            chk("bp_gap", cmd_cyc[1] - done_cyc[0], 2);
        end else begin
            chk("bp_dones", done_cyc.size(), 2);
        end

        // Reset during the CAS wait of burst 2 of 4.
        clear_logs();
        send(2'd1, 3'd4, 16'h0400);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_size", buf_burst_size, 2'd0);
        repeat (20) tick();
        chk("rst_cmds", cmd_cyc.size(), 2);
        chk("rst_no_done", done_cyc.size(), 0);
        send(2'd0, 3'd1, 16'h0500);
        wait_ready();
        chk("rst_new_done", done_cyc.size(), 1);

        // Randomized traffic with occasional resets and strobe noise.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_size  = 2'($urandom_range(0, 3));
            req_count = 3'($urandom_range(0, 7));
            req_addr  = 16'($urandom);
            dqs_seen  = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        dqs_seen  = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
